tcdm_bank_arbiter: RTL and testbench

Per-bank request arbiter and response router for the single-channel TCDM interconnect. Sits in front of one TCDM bank, selects one of `NumMaster` competing initiators per cycle, forwards its request to the bank, and routes the bank's read response back to the winner one cycle later. Supports round-robin and fixed-priority policies. An optional starvation guard bounds wait time under fixed priority.

---
 rtl/tcdm_arb_pkg.sv | 11 +
 rtl/tcdm_rr_sel.sv | 28 ++
 rtl/tcdm_bank_arbiter.sv | 127 ++++++++++++
 tb/tb_tcdm_bank_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_arb_pkg.sv
// Shared types and constants for the TCDM bank arbiter.
package tcdm_arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_policy_e;

  localparam int unsigned STARVE_CNT_W = 8;

endpackage

// File: rtl/tcdm_rr_sel.sv
// Combinational one-hot selector: first requester at or after 'start', wrapping.
module tcdm_rr_sel #(
  parameter int unsigned NumReq = 8
) (
  input  logic [NumReq-1:0]         req,
  input  logic [$clog2(NumReq)-1:0] start,
  output logic [NumReq-1:0]         sel
);

  localparam int unsigned IdxW = $clog2(NumReq);

  logic            found;
  logic [IdxW-1:0] idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = IdxW'((32'(start) + i) % NumReq);
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Per-bank TCDM arbiter (round-robin / fixed priority) with one-cycle response routing.
// Optional starvation guard for fixed priority: define TCDM_ARB_STARVE_GUARD_EN.
module tcdm_bank_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NumMaster    = 8,
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned StarveLimit  = 15
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     policy_i,
  input  logic [NumMaster-1:0]                     req_i,
  input  logic [NumMaster-1:0][AddrMemWidth-1:0]   add_i,
  input  logic [NumMaster-1:0]                     wen_i,
  input  logic [NumMaster-1:0][DataWidth-1:0]      wdata_i,
  input  logic [NumMaster-1:0][BeWidth-1:0]        be_i,
  output logic [NumMaster-1:0]                     gnt_o,
  output logic [NumMaster-1:0]                     rvld_o,
  output logic [DataWidth-1:0]                     rdata_o,
  output logic                                     cs_o,
  output logic [AddrMemWidth-1:0]                  add_o,
  output logic                                     wen_o,
  output logic [DataWidth-1:0]                     wdata_o,
  output logic [BeWidth-1:0]                       be_o,
  input  logic                                     gnt_i,
  input  logic [DataWidth-1:0]                     rdata_i
);

  localparam int unsigned RrW = $clog2(NumMaster);

  if (NumMaster < 2 || StarveLimit < 1 || StarveLimit > 255) begin : g_bad_cfg
    $error("tcdm_bank_arbiter: unsupported NumMaster or StarveLimit");
  end

  logic [RrW-1:0]       rr_q;
  logic [RrW-1:0]       win_idx;
  logic [NumMaster-1:0] id_q;
  logic                 vld_q;
  logic                 fixed;
  logic                 hs;
  logic [NumMaster-1:0] sel_norm;
  logic [NumMaster-1:0] sel;

  assign fixed = (arb_policy_e'(policy_i) == ARB_FIXED);

  tcdm_rr_sel #(
    .NumReq (NumMaster)
  ) u_sel (
    .req   (req_i),
    .start (fixed ? {RrW{1'b0}} : rr_q),
    .sel   (sel_norm)
  );

`ifdef TCDM_ARB_STARVE_GUARD_EN
  logic [NumMaster-1:0][STARVE_CNT_W-1:0] cnt_q;
  logic [NumMaster-1:0]                   starved;

  // A stale counter of a withdrawn request must not steal the grant.
  always_comb begin
    for (int unsigned k = 0; k < NumMaster; k++) begin
      starved[k] = req_i[k] && (cnt_q[k] >= STARVE_CNT_W'(StarveLimit));
    end
  end

  assign sel = (fixed && |starved) ? (starved & (~starved + NumMaster'(1))) : sel_norm;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (gnt_i) begin
      for (int unsigned k = 0; k < NumMaster; k++) begin
        if (!req_i[k] || gnt_o[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] != '1) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end
`else
  assign sel = sel_norm;
`endif

  assign cs_o    = ~rst_i & (|req_i);
  assign gnt_o   = sel & {NumMaster{gnt_i & ~rst_i}};
  assign rvld_o  = id_q & {NumMaster{vld_q & ~rst_i}};
  assign rdata_o = rdata_i;
  assign hs      = cs_o & gnt_i;

  always_comb begin
    win_idx = '0;
    add_o   = '0;
    wen_o   = 1'b0;
    wdata_o = '0;
    be_o    = '0;
    for (int unsigned k = 0; k < NumMaster; k++) begin
      if (sel[k]) begin
        win_idx = RrW'(k);
        add_o   = add_i[k];
        wen_o   = wen_i[k];
        wdata_o = wdata_i[k];
        be_o    = be_i[k];
      end
    end
  end

  // Request/response boundary: winner identity is held for the bank's read cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q  <= '0;
      id_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= hs;
      if (hs) begin
        id_q <= sel;
        if (!fixed) begin
          rr_q <= (win_idx == RrW'(NumMaster - 1)) ? '0 : win_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Self-checking bench for tcdm_bank_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_tcdm_bank_arbiter;

  localparam int N   = 8;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LIM = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 policy = 1'b0;
  logic                 bgnt = 1'b0;
  logic [N-1:0]         req = '0;
  logic [N-1:0]         wen = '0;
  logic [N-1:0][AW-1:0] add = '0;
  logic [N-1:0][DW-1:0] wdata = '0;
  logic [N-1:0][BW-1:0] be = '0;
  logic [DW-1:0]        brdata = '0;

  logic [N-1:0]  gnt, rvld;
  logic [DW-1:0] rdata_o, wdata_o;
  logic          cs, wen_o;
  logic [AW-1:0] add_o;
  logic [BW-1:0] be_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  tcdm_bank_arbiter #(
    .NumMaster    (N),
    .AddrMemWidth (AW),
    .DataWidth    (DW),
    .BeWidth      (BW),
    .StarveLimit  (LIM)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .policy_i (policy),
    .req_i    (req),
    .add_i    (add),
    .wen_i    (wen),
    .wdata_i  (wdata),
    .be_i     (be),
    .gnt_o    (gnt),
    .rvld_o   (rvld),
    .rdata_o  (rdata_o),
    .cs_o     (cs),
    .add_o    (add_o),
    .wen_o    (wen_o),
    .wdata_o  (wdata_o),
    .be_o     (be_o),
    .gnt_i    (bgnt),
    .rdata_i  (brdata)
  );

  // Reference model state: priority pointer, pending response, wait counters.
  int           m_rr = 0;
  logic         m_vld = 1'b0;
  logic [N-1:0] m_id = '0;
  int           m_cnt [N];
  logic [N-1:0] exp_sel, exp_gnt, exp_rvld;
  logic         exp_cs;
  int           exp_idx;

  task automatic model_expect();
    int pick;
    pick = -1;
    if (!rst && req != '0) begin
      if (policy) begin
        for (int i = N - 1; i >= 0; i--) if (req[i]) pick = i;
`ifdef TCDM_ARB_STARVE_GUARD_EN
        begin
          int starved_pick;
          starved_pick = -1;
          for (int i = N - 1; i >= 0; i--) if (req[i] && m_cnt[i] >= LIM) starved_pick = i;
          if (starved_pick >= 0) pick = starved_pick;
        end
`endif
      end else begin
        for (int i = N - 1; i >= 0; i--) if (req[(m_rr + i) % N]) pick = (m_rr + i) % N;
      end
    end
    exp_idx  = (pick < 0) ? 0 : pick;
    exp_sel  = (pick < 0) ? '0 : (N'(1) << pick);
    exp_gnt  = bgnt ? exp_sel : '0;
    exp_cs   = !rst && (req != '0);
    exp_rvld = (!rst && m_vld) ? m_id : '0;
  endtask

  task automatic model_clock();
    if (rst) begin
      m_rr = 0; m_vld = 1'b0; m_id = '0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else begin
      m_vld = exp_cs && bgnt;
      if (m_vld) begin
        m_id = exp_sel;
        if (!policy) m_rr = (exp_idx + 1) % N;
      end
      if (bgnt) begin
        for (int k = 0; k < N; k++) begin
          if (!req[k] || exp_gnt[k]) m_cnt[k] = 0;
          else if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_expect();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; bgnt = 1'b1; policy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (cs !== 1'b0) $display("FAIL reset_cs cyc %0d: got %b want 0", i, cs); else passed++;
      checks++; if (gnt !== '0) $display("FAIL reset_gnt cyc %0d: got %h want 00", i, gnt); else passed++;
      checks++; if (rvld !== '0) $display("FAIL reset_rvld cyc %0d: got %h want 00", i, rvld); else passed++;
      tick();
    end
  endtask

  task automatic test_rr_rotation();
    logic [N-1:0] want_g, want_v;
    rst = 1'b0; policy = 1'b0; req = '1; bgnt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      brdata = $urandom;
      #1;
      want_g = N'(1) << (i % N);
      want_v = (i == 0) ? '0 : (N'(1) << ((i - 1) % N));
      checks++; if (gnt !== want_g) $display("FAIL rr_gnt cyc %0d: got %h want %h", i, gnt, want_g); else passed++;
      checks++; if (rvld !== want_v) $display("FAIL rr_rvld cyc %0d: got %h want %h", i, rvld, want_v); else passed++;
      checks++; if (rdata_o !== brdata) $display("FAIL rr_rdata cyc %0d: got %h want %h", i, rdata_o, brdata); else passed++;
      tick();
    end
  endtask

  task automatic test_fixed_priority();
    logic [N-1:0] want_g;
    req = '0; bgnt = 1'b1;
    tick();
    policy = 1'b1; req = 8'h81;
    for (int i = 0; i < 20; i++) begin
      #1;
`ifdef TCDM_ARB_STARVE_GUARD_EN
      want_g = ((i + 1) % (LIM + 1) == 0) ? 8'h80 : 8'h01;
`else
      want_g = 8'h01;
`endif
      checks++; if (gnt !== want_g) $display("FAIL fixed_gnt cyc %0d: got %h want %h", i, gnt, want_g); else passed++;
      tick();
    end
  endtask

  task automatic test_bank_stall();
    rst = 1'b1; req = '0; bgnt = 1'b1;
    tick();
    rst = 1'b0; policy = 1'b0; req = 8'h06; bgnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (cs !== 1'b1) $display("FAIL stall_cs cyc %0d: got %b want 1", i, cs); else passed++;
      checks++; if (gnt !== '0) $display("FAIL stall_gnt cyc %0d: got %h want 00", i, gnt); else passed++;
      checks++; if (rvld !== '0) $display("FAIL stall_rvld cyc %0d: got %h want 00", i, rvld); else passed++;
      tick();
    end
    bgnt = 1'b1;
    #1;
    checks++; if (gnt !== 8'h02) $display("FAIL stall_release_gnt: got %h want 02", gnt); else passed++;
    tick();
    req = '0; brdata = $urandom;
    #1;
    checks++; if (rvld !== 8'h02) $display("FAIL stall_rvld_after: got %h want 02", rvld); else passed++;
    checks++; if (rdata_o !== brdata) $display("FAIL stall_rdata: got %h want %h", rdata_o, brdata); else passed++;
    tick();
  endtask

  task automatic test_load_routing();
    policy = 1'b0; bgnt = 1'b1;
    for (int k = 0; k < N; k++) begin
      add[k] = AW'($urandom); wdata[k] = $urandom; be[k] = BW'($urandom);
    end
    wen = 8'h00; wen[3] = 1'b1; add[3] = 12'h0A5; req = 8'h08;
    #1;
    checks++; if (gnt !== 8'h08) $display("FAIL load_gnt: got %h want 08", gnt); else passed++;
    checks++; if (add_o !== 12'h0A5) $display("FAIL load_add: got %h want 0a5", add_o); else passed++;
    checks++; if (wen_o !== 1'b1) $display("FAIL load_wen: got %b want 1", wen_o); else passed++;
    tick();
    req = '0; brdata = 32'hDEADBEEF;
    #1;
    checks++; if (rvld !== 8'h08) $display("FAIL load_rvld: got %h want 08", rvld); else passed++;
    checks++; if (rdata_o !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h want deadbeef", rdata_o); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    policy = 1'b0; bgnt = 1'b1; req = 8'h20;
    #1;
    checks++; if (gnt !== 8'h20) $display("FAIL rstmid_gnt: got %h want 20", gnt); else passed++;
    tick();
    rst = 1'b1; req = '1;
    #1;
    checks++; if (rvld !== '0) $display("FAIL rstmid_rvld_during: got %h want 00", rvld); else passed++;
    checks++; if (gnt !== '0) $display("FAIL rstmid_gnt_during: got %h want 00", gnt); else passed++;
    checks++; if (cs !== 1'b0) $display("FAIL rstmid_cs_during: got %b want 0", cs); else passed++;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 8'h01) $display("FAIL rstmid_first_gnt: got %h want 01", gnt); else passed++;
    checks++; if (rvld !== '0) $display("FAIL rstmid_rvld_after: got %h want 00", rvld); else passed++;
    tick();
    req = '0;
    #1;
    checks++; if (rvld !== 8'h01) $display("FAIL rstmid_rvld_resume: got %h want 01", rvld); else passed++;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (c % 8 == 0) policy = $urandom_range(0, 1) != 0;
      bgnt = ($urandom_range(0, 3) != 0);
      req = N'($urandom) & N'($urandom | $urandom);
      wen = N'($urandom);
      for (int k = 0; k < N; k++) begin
        add[k] = AW'($urandom); wdata[k] = $urandom; be[k] = BW'($urandom);
      end
      brdata = $urandom;
      #1;
      model_expect();
      checks++; if (gnt !== exp_gnt) $display("FAIL rand_gnt cyc %0d: got %h want %h", c, gnt, exp_gnt); else passed++;
      checks++; if (cs !== exp_cs) $display("FAIL rand_cs cyc %0d: got %b want %b", c, cs, exp_cs); else passed++;
      checks++; if (rvld !== exp_rvld) $display("FAIL rand_rvld cyc %0d: got %h want %h", c, rvld, exp_rvld); else passed++;
      checks++; if (rdata_o !== brdata) $display("FAIL rand_rdata cyc %0d: got %h want %h", c, rdata_o, brdata); else passed++;
      if (exp_sel != '0) begin
        checks++;
        if (add_o !== add[exp_idx] || wen_o !== wen[exp_idx] || wdata_o !== wdata[exp_idx] || be_o !== be[exp_idx])
          $display("FAIL rand_mux cyc %0d: got %h/%b/%h/%h want %h/%b/%h/%h", c, add_o, wen_o, wdata_o, be_o,
                   add[exp_idx], wen[exp_idx], wdata[exp_idx], be[exp_idx]);
        else passed++;
      end
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_rr_rotation();
    test_fixed_priority();
    test_bank_stall();
    test_load_routing();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
